// File: rtl/ticket_payment_collector.sv
// ticket_payment_collector
//   Settles one fare from the fare calculator against coins and notes taken
//   from the coin acceptor. Exact payment issues a ticket. Overpayment first
//   dispenses change greedily through the coin dispenser, then issues the
//   ticket. A cancel or an idle timeout refunds everything paid, using the
//   same greedy dispense path.
// Ports
//   clk, rd                      clock (rising edge), async active-low reset
//   fare_valid/fare/fare_ready   fare handshake (16-bit rupees)
//   coin_valid/coin_code/coin_ready  coin acceptor handshake (code 0..7)
//   cancel                       passenger abort (honoured in COLLECT only)
//   change_valid/change_code/change_ready  coin dispenser handshake
//   ticket_issue, refund_done    one-cycle completion pulses
//   balance_due                  fare minus paid while collecting, else 0
//   busy                         high whenever not idle
module ticket_payment_collector #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 16
) (
  input  logic        clk,
  input  logic        rd,
  input  logic        fare_valid,
  input  logic [15:0] fare,
  output logic        fare_ready,
  input  logic        coin_valid,
  input  logic [2:0]  coin_code,
  output logic        coin_ready,
  input  logic        cancel,
  output logic        change_valid,
  output logic [2:0]  change_code,
  input  logic        change_ready,
  output logic        ticket_issue,
  output logic        refund_done,
  output logic [16:0] balance_due,
  output logic        busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_CHANGE  = 3'd2;
  localparam logic [2:0] S_REFUND  = 3'd3;
  localparam logic [2:0] S_ISSUE   = 3'd4;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [16:0] coin_value(input logic [2:0] code);
    case (code)
      3'd0:    coin_value = 17'd1;
      3'd1:    coin_value = 17'd2;
      3'd2:    coin_value = 17'd5;
      3'd3:    coin_value = 17'd10;
      3'd4:    coin_value = 17'd20;
      3'd5:    coin_value = 17'd50;
      3'd6:    coin_value = 17'd100;
      default: coin_value = 17'd500;
    endcase
  endfunction

  // Largest denomination not exceeding the amount still owed.
  function automatic logic [2:0] greedy_code(input logic [16:0] amt);
    if      (amt >= 17'd500) greedy_code = 3'd7;
    else if (amt >= 17'd100) greedy_code = 3'd6;
    else if (amt >= 17'd50)  greedy_code = 3'd5;
    else if (amt >= 17'd20)  greedy_code = 3'd4;
    else if (amt >= 17'd10)  greedy_code = 3'd3;
    else if (amt >= 17'd5)   greedy_code = 3'd2;
    else if (amt >= 17'd2)   greedy_code = 3'd1;
    else                     greedy_code = 3'd0;
  endfunction

  logic [2:0]      state_q, state_d;
  logic [15:0]     fare_q, fare_d;
  logic [16:0]     paid_q, paid_d;
  logic [16:0]     rem_q, rem_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [2:0]      code_q, code_d;
  logic            refund_q, refund_d;

  logic [16:0] paid_nx;
  logic [16:0] rem_nx;
  logic        coin_hs;
  logic        change_hs;

  // Handshake outputs. fare_ready is gated by rd so every output reads 0
  // while reset is held, not only after the next edge.
  assign fare_ready   = rd && (state_q == S_IDLE);
  assign coin_ready   = (state_q == S_COLLECT) && !cancel;
  assign change_valid = (state_q == S_CHANGE) || (state_q == S_REFUND);
  assign change_code  = change_valid ? code_q : 3'd0;
  assign ticket_issue = (state_q == S_ISSUE);
  assign refund_done  = refund_q;
  assign busy         = (state_q != S_IDLE);
  assign balance_due  = (state_q == S_COLLECT) ? ({1'b0, fare_q} - paid_q) : 17'd0;

  assign coin_hs   = coin_valid && coin_ready;
  assign change_hs = change_valid && change_ready;

  always_comb begin
    state_d  = state_q;
    fare_d   = fare_q;
    paid_d   = paid_q;
    rem_d    = rem_q;
    to_d     = to_q;
    code_d   = code_q;
    refund_d = 1'b0;
    paid_nx  = paid_q;
    rem_nx   = rem_q;

    case (state_q)
      S_IDLE: begin
        if (fare_valid && fare_ready) begin
          fare_d  = fare;
          paid_d  = 17'd0;
          to_d    = '0;
          state_d = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // Settlement is judged on the post-coin total so a coin taken on
        // the exit edge is never lost.
        paid_nx = coin_hs ? (paid_q + coin_value(coin_code)) : paid_q;
        paid_d  = paid_nx;
        to_d    = coin_hs ? '0 : (to_q + 1'b1);
        if (paid_nx == {1'b0, fare_q}) begin
          state_d = S_ISSUE;
        end else if (paid_nx > {1'b0, fare_q}) begin
          rem_d   = paid_nx - {1'b0, fare_q};
          code_d  = greedy_code(paid_nx - {1'b0, fare_q});
          state_d = S_CHANGE;
        end else if (cancel || ((to_q == TO_LAST) && !coin_hs)) begin
          rem_d  = paid_q;
          code_d = greedy_code(paid_q);
          if (paid_q == 17'd0) begin
            refund_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_REFUND;
          end
        end
      end

      S_CHANGE, S_REFUND: begin
        if (change_hs) begin
          rem_nx = rem_q - coin_value(code_q);
          rem_d  = rem_nx;
          code_d = greedy_code(rem_nx);
          if (rem_nx == 17'd0) begin
            if (state_q == S_CHANGE) begin
              state_d = S_ISSUE;
            end else begin
              refund_d = 1'b1;
              state_d  = S_IDLE;
            end
          end
        end
      end

      S_ISSUE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      state_q  <= S_IDLE;
      fare_q   <= '0;
      paid_q   <= '0;
      rem_q    <= '0;
      to_q     <= '0;
      code_q   <= '0;
      refund_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fare_q   <= fare_d;
      paid_q   <= paid_d;
      rem_q    <= rem_d;
      to_q     <= to_d;
      code_q   <= code_d;
      refund_q <= refund_d;
    end
  end

endmodule

// File: tb/tb_ticket_payment_collector.sv
module tb_ticket_payment_collector;

  logic        clk;
  logic        rd;
  logic        fare_valid;
  logic [15:0] fare;
  logic        fare_ready;
  logic        coin_valid;
  logic [2:0]  coin_code;
  logic        coin_ready;
  logic        cancel;
  logic        change_valid;
  logic [2:0]  change_code;
  logic        change_ready;
  logic        ticket_issue;
  logic        refund_done;
  logic [16:0] balance_due;
  logic        busy;

  int errors = 0;
  int checks = 0;

  ticket_payment_collector #(.TIMEOUT_CYCLES(8), .TO_W(16)) dut (
    .clk(clk), .rd(rd),
    .fare_valid(fare_valid), .fare(fare), .fare_ready(fare_ready),
    .coin_valid(coin_valid), .coin_code(coin_code), .coin_ready(coin_ready),
    .cancel(cancel),
    .change_valid(change_valid), .change_code(change_code), .change_ready(change_ready),
    .ticket_issue(ticket_issue), .refund_done(refund_done),
    .balance_due(balance_due), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic give_fare(input logic [15:0] f);
    fare_valid = 1'b1;
    fare       = f;
    step();
    fare_valid = 1'b0;
  endtask

  task automatic insert_coin(input logic [2:0] c);
    coin_valid = 1'b1;
    coin_code  = c;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic test_reset();
    rd = 1'b0; fare_valid = 1'b0; fare = '0; coin_valid = 1'b0; coin_code = '0;
    cancel = 1'b0; change_ready = 1'b0;
    #2;
    checks++;
    if ({fare_ready, coin_ready, change_valid, change_code, ticket_issue, refund_done, busy} !== 9'd0 ||
        balance_due !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%0b busy=%0b cv=%0b bal=%0d expected all 0",
               fare_ready, busy, change_valid, balance_due);
    end
    step(); step();
    rd = 1'b1;
    #1;
    checks++;
    if (fare_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %0b expected 1", fare_ready);
    end
  endtask

  task automatic test_exact_change();
    give_fare(16'd35);
    checks++;
    if (balance_due !== 17'd35 || busy !== 1'b1 || fare_ready !== 1'b0) begin
      errors++; $display("FAIL chg_entry: got bal=%0d busy=%0b fr=%0b expected 35 1 0",
                         balance_due, busy, fare_ready);
    end
    coin_valid = 1'b1; coin_code = 3'd4;
    checks++;
    if (coin_ready !== 1'b1) begin
      errors++; $display("FAIL chg_coin_ready: got %0b expected 1", coin_ready);
    end
    step(); coin_valid = 1'b0;
    checks++;
    if (balance_due !== 17'd15) begin
      errors++; $display("FAIL chg_balance15: got %0d expected 15", balance_due);
    end
    insert_coin(3'd4);
    checks++;
    if (change_valid !== 1'b1 || change_code !== 3'd2 || balance_due !== 17'd0) begin
      errors++; $display("FAIL chg_code: got cv=%0b code=%0d bal=%0d expected 1 2 0",
                         change_valid, change_code, balance_due);
    end
    change_ready = 1'b1; step(); change_ready = 1'b0;
    checks++;
    if (ticket_issue !== 1'b1 || change_valid !== 1'b0 || refund_done !== 1'b0) begin
      errors++; $display("FAIL chg_ticket: got ti=%0b cv=%0b rf=%0b expected 1 0 0",
                         ticket_issue, change_valid, refund_done);
    end
    step();
    checks++;
    if (ticket_issue !== 1'b0 || fare_ready !== 1'b1 || refund_done !== 1'b0) begin
      errors++; $display("FAIL chg_done: got ti=%0b fr=%0b rf=%0b expected 0 1 0",
                         ticket_issue, fare_ready, refund_done);
    end
  endtask

  task automatic test_zero_fare();
    give_fare(16'd0);
    checks++;
    if (ticket_issue !== 1'b0 || change_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_collect: got ti=%0b cv=%0b busy=%0b expected 0 0 1",
                         ticket_issue, change_valid, busy);
    end
    step();
    checks++;
    if (ticket_issue !== 1'b1 || change_valid !== 1'b0) begin
      errors++; $display("FAIL zero_ticket: got ti=%0b cv=%0b expected 1 0", ticket_issue, change_valid);
    end
    step();
    checks++;
    if (ticket_issue !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_idle: got ti=%0b busy=%0b expected 0 0", ticket_issue, busy);
    end
  endtask

  task automatic test_cancel_refund();
    give_fare(16'd100);
    insert_coin(3'd3);
    insert_coin(3'd2);
    checks++;
    if (balance_due !== 17'd85) begin
      errors++; $display("FAIL cxl_balance: got %0d expected 85", balance_due);
    end
    cancel = 1'b1;
    #1;
    checks++;
    if (coin_ready !== 1'b0) begin
      errors++; $display("FAIL cxl_coin_ready: got %0b expected 0", coin_ready);
    end
    step(); cancel = 1'b0;
    checks++;
    if (change_valid !== 1'b1 || change_code !== 3'd3 || ticket_issue !== 1'b0) begin
      errors++; $display("FAIL cxl_first: got cv=%0b code=%0d ti=%0b expected 1 3 0",
                         change_valid, change_code, ticket_issue);
    end
    change_ready = 1'b1; step();
    checks++;
    if (change_valid !== 1'b1 || change_code !== 3'd2) begin
      errors++; $display("FAIL cxl_second: got cv=%0b code=%0d expected 1 2", change_valid, change_code);
    end
    step(); change_ready = 1'b0;
    checks++;
    if (refund_done !== 1'b1 || change_valid !== 1'b0 || ticket_issue !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL cxl_done: got rf=%0b cv=%0b ti=%0b busy=%0b expected 1 0 0 0",
                         refund_done, change_valid, ticket_issue, busy);
    end
    step();
    checks++;
    if (refund_done !== 1'b0) begin
      errors++; $display("FAIL cxl_pulse: got %0b expected 0", refund_done);
    end
  endtask

  task automatic test_timeout();
    int n;
    give_fare(16'd50);
    n = 0;
    while (refund_done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== 8) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles expected 8", n);
    end
    checks++;
    if (busy !== 1'b0 || ticket_issue !== 1'b0) begin
      errors++; $display("FAIL timeout_state: got busy=%0b ti=%0b expected 0 0", busy, ticket_issue);
    end
    step();
  endtask

  task automatic test_big_change();
    logic [2:0] exp_codes [9] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd5, 3'd4, 3'd4, 3'd1, 3'd0};
    give_fare(16'd7);
    insert_coin(3'd7);
    for (int i = 0; i < 9; i++) begin
      for (int h = 0; h < 3; h++) begin
        checks++;
        if (change_valid !== 1'b1 || change_code !== exp_codes[i]) begin
          errors++; $display("FAIL big_code[%0d] hold%0d: got cv=%0b code=%0d expected 1 %0d",
                             i, h, change_valid, change_code, exp_codes[i]);
        end
        step();
      end
      change_ready = 1'b1; step(); change_ready = 1'b0;
    end
    checks++;
    if (ticket_issue !== 1'b1 || change_valid !== 1'b0 || refund_done !== 1'b0) begin
      errors++; $display("FAIL big_ticket: got ti=%0b cv=%0b rf=%0b expected 1 0 0",
                         ticket_issue, change_valid, refund_done);
    end
    step();
  endtask

  task automatic test_coin_with_cancel();
    give_fare(16'd20);
    insert_coin(3'd1);
    checks++;
    if (balance_due !== 17'd18) begin
      errors++; $display("FAIL cc_balance: got %0d expected 18", balance_due);
    end
    coin_valid = 1'b1; coin_code = 3'd0; cancel = 1'b1;
    #1;
    checks++;
    if (coin_ready !== 1'b0) begin
      errors++; $display("FAIL cc_coin_ready: got %0b expected 0", coin_ready);
    end
    step(); coin_valid = 1'b0; cancel = 1'b0;
    checks++;
    if (change_valid !== 1'b1 || change_code !== 3'd1) begin
      errors++; $display("FAIL cc_refund_code: got cv=%0b code=%0d expected 1 1", change_valid, change_code);
    end
    change_ready = 1'b1; step(); change_ready = 1'b0;
    checks++;
    if (refund_done !== 1'b1 || change_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL cc_done: got rf=%0b cv=%0b busy=%0b expected 1 0 0",
                         refund_done, change_valid, busy);
    end
    step();
  endtask

  task automatic test_reset_mid_change();
    give_fare(16'd3);
    insert_coin(3'd2);
    checks++;
    if (change_valid !== 1'b1 || change_code !== 3'd1) begin
      errors++; $display("FAIL rst_pre: got cv=%0b code=%0d expected 1 1", change_valid, change_code);
    end
    #2;
    rd = 1'b0;
    #1;
    checks++;
    if (change_valid !== 1'b0 || busy !== 1'b0 || balance_due !== 17'd0 || fare_ready !== 1'b0) begin
      errors++; $display("FAIL rst_async: got cv=%0b busy=%0b bal=%0d fr=%0b expected 0 0 0 0",
                         change_valid, busy, balance_due, fare_ready);
    end
    step();
    rd = 1'b1;
    #1;
    checks++;
    if (fare_ready !== 1'b1 || busy !== 1'b0 || refund_done !== 1'b0) begin
      errors++; $display("FAIL rst_release: got fr=%0b busy=%0b rf=%0b expected 1 0 0",
                         fare_ready, busy, refund_done);
    end
  endtask

  initial begin
    test_reset();
    test_exact_change();
    test_zero_fare();
    test_cancel_refund();
    test_timeout();
    test_big_change();
    test_coin_with_cancel();
    test_reset_mid_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
